// File: rtl/layer_header_fetch.sv
// Per-frame layer header scanner: walks every layer once per frame_start, reads all
// header registers through the async memory read ports and streams enabled layers out.
module layer_header_fetch #(
   parameter int NUM_LAYERS = 32,
   parameter int NUM_REGS   = 4,
   parameter int ENABLE_BIT = 15
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     frame_start,
   output logic [4:0]               mem_read_addr,
   input  logic [NUM_REGS*16-1:0]   mem_read_data,
   output logic                     hdr_valid,
   input  logic                     hdr_ready,
   output logic [4:0]               hdr_layer,
   output logic [NUM_REGS*16-1:0]   hdr_data,
   output logic                     scan_busy,
   output logic                     scan_done,
   output logic                     frame_overrun
);

   localparam logic [4:0] LAST_LAYER = 5'(NUM_LAYERS - 1);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SCAN  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   state_t                   state_q, state_d;
   logic [4:0]               layer_q, layer_d;
   logic                     hdr_valid_q, hdr_valid_d;
   logic [4:0]               hdr_layer_q, hdr_layer_d;
   logic [NUM_REGS*16-1:0]   hdr_data_q, hdr_data_d;
   logic                     frame_overrun_q, frame_overrun_d;

   logic handshake_s;
   logic load_ok_s;
   logic layer_en_s;
   logic load_s;
   logic last_s;

   // Next-state, output-register and layer-counter computation.
   always_comb begin
      handshake_s     = hdr_valid_q && hdr_ready;
      load_ok_s       = !hdr_valid_q || hdr_ready;
      layer_en_s      = mem_read_data[ENABLE_BIT];
      last_s          = (layer_q == LAST_LAYER);
      load_s          = (state_q == ST_SCAN) && load_ok_s && layer_en_s;

      state_d         = state_q;
      layer_d         = layer_q;
      hdr_valid_d     = hdr_valid_q;
      hdr_layer_d     = hdr_layer_q;
      hdr_data_d      = hdr_data_q;
      frame_overrun_d = frame_overrun_q | (frame_start && (state_q != ST_IDLE));

      if (load_s) begin
         hdr_valid_d = 1'b1;
         hdr_layer_d = layer_q;
         hdr_data_d  = mem_read_data;
      end else if (handshake_s) begin
         hdr_valid_d = 1'b0;
      end else begin
         hdr_valid_d = hdr_valid_q;
      end

      case (state_q)
         ST_IDLE: begin
            if (frame_start) begin
               state_d = ST_SCAN;
               layer_d = 5'd0;
            end else begin
               layer_d = 5'd0;
            end
         end
         ST_SCAN: begin
            // The last layer moves to DRAIN rather than wrapping the counter.
            if (load_ok_s && last_s) begin
               state_d = ST_DRAIN;
            end else if (load_ok_s) begin
               layer_d = layer_q + 5'd1;
            end else begin
               layer_d = layer_q;
            end
         end
         ST_DRAIN: begin
            if (!hdr_valid_q) begin
               state_d = ST_IDLE;
               layer_d = 5'd0;
            end else begin
               state_d = ST_DRAIN;
            end
         end
         default: begin
            state_d = ST_IDLE;
            layer_d = 5'd0;
         end
      endcase
   end

   // State and output registers; reset aborts any scan and drops the pending header.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q         <= ST_IDLE;
         layer_q         <= 5'd0;
         hdr_valid_q     <= 1'b0;
         hdr_layer_q     <= 5'd0;
         hdr_data_q      <= '0;
         frame_overrun_q <= 1'b0;
      end else begin
         state_q         <= state_d;
         layer_q         <= layer_d;
         hdr_valid_q     <= hdr_valid_d;
         hdr_layer_q     <= hdr_layer_d;
         hdr_data_q      <= hdr_data_d;
         frame_overrun_q <= frame_overrun_d;
      end
   end

   assign mem_read_addr = layer_q;
   assign hdr_valid     = hdr_valid_q;
   assign hdr_layer     = hdr_layer_q;
   assign hdr_data      = hdr_data_q;
   assign frame_overrun = frame_overrun_q;
   assign scan_busy     = (state_q != ST_IDLE);
   assign scan_done     = (state_q == ST_DRAIN) && !hdr_valid_q;

endmodule

// File: tb/tb_layer_header_fetch.sv
// Bench for layer_header_fetch: a header-memory model plus a queue of expected
// enabled-layer headers, with cycle timing predicted for the always-ready case.
module tb_layer_header_fetch;

   localparam int NL     = 32;
   localparam int NR     = 4;
   localparam int BUDGET = 400;

   typedef struct {
      logic [4:0]       layer;
      logic [NR*16-1:0] data;
   } hdr_t;

   logic              clk;
   logic              reset;
   logic              frame_start;
   logic [4:0]        mem_read_addr;
   logic [NR*16-1:0]  mem_read_data;
   logic              hdr_valid;
   logic              hdr_ready;
   logic [4:0]        hdr_layer;
   logic [NR*16-1:0]  hdr_data;
   logic              scan_busy;
   logic              scan_done;
   logic              frame_overrun;

   logic [15:0] mem [0:NL-1][0:NR-1];
   logic [31:0] en_mask;
   int total = 0;
   int bad   = 0;

   layer_header_fetch #(.NUM_LAYERS(NL), .NUM_REGS(NR), .ENABLE_BIT(15)) dut (
      .clk(clk), .reset(reset), .frame_start(frame_start),
      .mem_read_addr(mem_read_addr), .mem_read_data(mem_read_data),
      .hdr_valid(hdr_valid), .hdr_ready(hdr_ready), .hdr_layer(hdr_layer),
      .hdr_data(hdr_data), .scan_busy(scan_busy), .scan_done(scan_done),
      .frame_overrun(frame_overrun)
   );

   for (genvar g = 0; g < NR; g++) begin : g_rd
      assign mem_read_data[16*g +: 16] = mem[mem_read_addr][g];
   end

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic fill(input logic [31:0] en, input bit rnd);
      logic [15:0] v;
      en_mask = en;
      for (int l = 0; l < NL; l++) begin
         for (int r = 0; r < NR; r++) begin
            v = rnd ? 16'($urandom) : {1'b1, 3'(r), 12'(l)};
            if (r == 0) v[15] = en[l];
            mem[l][r] = v;
         end
      end
   endtask

   function automatic logic ready_for(input int mode, input int c);
      if (mode == 0) return 1'b1;
      if (mode == 1) return ((c % 4) == 0) || ((c % 4) == 3);
      return 1'($urandom_range(0, 1));
   endfunction

   task automatic check_all_zero(input string tag);
      check({tag, "_valid"}, hdr_valid, 0);
      check({tag, "_layer"}, hdr_layer, 0);
      check({tag, "_data"}, hdr_data, 0);
      check({tag, "_addr"}, mem_read_addr, 0);
      check({tag, "_busy"}, scan_busy, 0);
      check({tag, "_done"}, scan_done, 0);
      check({tag, "_ovr"}, frame_overrun, 0);
   endtask

   // mode 0: ready always high (exact timing predicted), 1: ready 1,0,0,1, 2: random ready.
   task automatic do_scan(input int mode, input int ovr_cycle, input int abort_cycle);
      hdr_t q[$];
      hdr_t h;
      int done_cycle = -1;
      int last_hs = -1;
      bit stall_prev = 1'b0;
      logic [4:0] held_layer, held_addr;
      logic [NR*16-1:0] held_data;
      logic exp_v;
      for (int l = 0; l < NL; l++) begin
         if (en_mask[l]) begin
            h.layer = 5'(l);
            for (int r = 0; r < NR; r++) h.data[16*r +: 16] = mem[l][r];
            q.push_back(h);
         end
      end
      @(posedge clk); #1;
      frame_start = 1'b1;
      hdr_ready = ready_for(mode, 0);
      @(negedge clk);
      check("busy_c0", scan_busy, 0);
      for (int c = 1; c <= BUDGET; c++) begin
         @(posedge clk); #1;
         frame_start = (c == ovr_cycle);
         hdr_ready = ready_for(mode, c);
         if (c == abort_cycle) begin
            check("valid_pre_abort", hdr_valid, 1);
            reset = 1'b0;
            #1;
            check_all_zero("abort");
            repeat (2) @(posedge clk);
            #1;
            frame_start = 1'b0;
            reset = 1'b1;
            return;
         end
         @(negedge clk);
         check("busy", scan_busy, 1);
         if (mode == 0) begin
            exp_v = (c >= 2 && c <= NL + 1) ? en_mask[c-2] : 1'b0;
            check("valid_timing", hdr_valid, exp_v);
            if (c <= NL) check("addr_timing", mem_read_addr, c - 1);
         end
         if (stall_prev) begin
            check("stall_valid", hdr_valid, 1);
            check("stall_layer", hdr_layer, held_layer);
            check("stall_data", hdr_data, held_data);
            check("stall_addr", mem_read_addr, held_addr);
         end
         if (hdr_valid && hdr_ready) begin
            if (q.size() == 0) begin
               check("extra_header", hdr_layer, 5'h1f ^ hdr_layer);
            end else begin
               h = q.pop_front();
               check("hdr_layer", hdr_layer, h.layer);
               check("hdr_data", hdr_data, h.data);
            end
            last_hs = c;
         end
         stall_prev = hdr_valid && !hdr_ready;
         held_layer = hdr_layer;
         held_data  = hdr_data;
         held_addr  = mem_read_addr;
         if (scan_done) begin
            done_cycle = c;
            check("valid_at_done", hdr_valid, 0);
            break;
         end
      end
      check("scan_done_seen", done_cycle >= 0, 1);
      check("headers_left", q.size(), 0);
      if (mode == 0) check("done_cycle", done_cycle, en_mask[NL-1] ? NL + 2 : NL + 1);
      if (en_mask[NL-1]) check("done_after_hs", done_cycle, last_hs + 1);
      @(posedge clk); #1;
      frame_start = 1'b0;
      @(negedge clk);
      check("idle_busy", scan_busy, 0);
      check("idle_done", scan_done, 0);
      check("idle_addr", mem_read_addr, 0);
   endtask

   initial begin
      reset = 1'b0;
      frame_start = 1'b0;
      hdr_ready = 1'b0;
      fill(32'hffff_ffff, 1'b0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      reset = 1'b1;

      fill(32'hffff_ffff, 1'b0);
      do_scan(0, -1, -1);

      fill(32'h8002_0008, 1'b0);
      do_scan(0, -1, -1);

      fill(32'hffff_ffff, 1'b0);
      do_scan(1, -1, -1);

      fill(32'h0000_0000, 1'b0);
      do_scan(0, -1, -1);

      fill(32'hffff_ffff, 1'b0);
      do_scan(0, 10, -1);
      check("overrun_set", frame_overrun, 1);
      fill($urandom, 1'b1);
      do_scan(0, -1, -1);
      check("overrun_sticky", frame_overrun, 1);

      fill(32'hffff_ffff, 1'b0);
      do_scan(0, -1, 15);
      do_scan(0, -1, -1);
      check("overrun_after_reset", frame_overrun, 0);

      for (int i = 0; i < 4; i++) begin
         fill($urandom | ((i % 2 == 0) ? 32'h8000_0000 : 32'h0), 1'b1);
         do_scan(2, -1, -1);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
